// File: rtl/railway_pkg.sv
// Shared definitions for the railway crossing blocks: crossing state encoding
// and the default sizing constants the conditioner and FSM benches agree on.
package railway_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OCCUPIED = 2'd1,
    S_FAULT    = 2'd2
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_OCC_W           = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

endpackage

// File: rtl/sensor_debounce.sv
// One track-circuit channel: two-flop synchroniser, debounce filter that only
// accepts a level after it has persisted DEBOUNCE_CYCLES synchronised cycles,
// and single-cycle rise/fall indications of the accepted level.
module sensor_debounce
  import railway_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_levelDly;
  logic [CNT_W-1:0] r_count;

  // Bring the asynchronous wheel detector into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only once it has been seen for the full debounce window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= 1'b0;
      r_count <= '0;
    end else if (r_sync2 == r_level) begin
      r_count <= '0;
    end else if (r_count == CNT_LAST) begin
      r_level <= r_sync2;
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Keep last cycle's accepted level so edges can be seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_levelDly <= 1'b0;
    end else begin
      r_levelDly <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_levelDly;
  assign o_fall  = ~r_level & r_levelDly;

endmodule

// File: rtl/train_detect_conditioner.sv
// Front end of the crossing controller: conditions the approach and exit
// sensors, counts trains between them, emits train_sensor / train_clear
// pulses, and latches a fail-safe fault on impossible histories or a stuck train.
module train_detect_conditioner
  import railway_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int OCC_W           = DEFAULT_OCC_W,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             approach_raw,
  input  logic             exit_raw,
  output logic             train_sensor,
  output logic             train_clear,
  output logic [OCC_W-1:0] occupancy,
  output logic             fault
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = '1;
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  logic w_approachLevel;
  logic w_exitLevel;
  logic w_entry;
  logic w_leave;
  logic w_approachFall;
  logic w_exitRise;
  logic w_unusedEdges;

  state_t           r_state;
  logic [OCC_W-1:0] r_occ;
  logic [TMR_W-1:0] r_timer;
  logic             r_trainSensor;
  logic             r_trainClear;
  logic             r_fault;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_approach (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (approach_raw),
    .o_level(w_approachLevel),
    .o_rise (w_entry),
    .o_fall (w_approachFall)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_exit (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (exit_raw),
    .o_level(w_exitLevel),
    .o_rise (w_exitRise),
    .o_fall (w_leave)
  );

  // Only an approach rise (train arrives) and an exit fall (train fully past)
  // matter; the other edges and raw levels are deliberately ignored.
  assign w_unusedEdges = w_approachFall | w_exitRise | w_approachLevel | w_exitLevel;

  // Occupancy tracking, stuck-train timeout and fail-safe latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_occ         <= '0;
      r_timer       <= '0;
      r_trainSensor <= 1'b0;
      r_trainClear  <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_trainSensor <= 1'b0;
      r_trainClear  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_leave) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_trainSensor <= 1'b1;
          end else if (w_entry) begin
            r_state       <= S_OCCUPIED;
            r_occ         <= OCC_ONE;
            r_trainSensor <= 1'b1;
          end
        end
        S_OCCUPIED: begin
          if (w_entry && w_leave) begin
            r_timer       <= '0;
            r_trainSensor <= 1'b1;
          end else if (w_entry) begin
            r_timer       <= '0;
            r_trainSensor <= 1'b1;
            if (r_occ == OCC_MAX) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_occ <= r_occ + 1'b1;
            end
          end else if (w_leave) begin
            r_timer <= '0;
            r_occ   <= r_occ - 1'b1;
            if (r_occ == OCC_ONE) begin
              r_trainClear <= 1'b1;
              r_state      <= S_IDLE;
            end
          end else if (r_timer == TMR_LAST) begin
            r_timer       <= r_timer + 1'b1;
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_trainSensor <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_FAULT: begin
          r_trainSensor <= 1'b1;
          r_fault       <= 1'b1;
        end
        default: begin
          r_state       <= S_FAULT;
          r_trainSensor <= 1'b1;
          r_fault       <= 1'b1;
        end
      endcase
    end
  end

  assign train_sensor = r_trainSensor;
  assign train_clear  = r_trainClear;
  assign occupancy    = r_occ;
  assign fault        = r_fault;

endmodule

// File: tb/tb_train_detect_conditioner.sv
// Directed bench for train_detect_conditioner. The stimulus thread queues the
// pulse each step should produce; an independent monitor pops and compares
// every time the block presents a pulse.
module tb_train_detect_conditioner;

  localparam int DEB  = 4;
  localparam int OCCW = 2;
  localparam int TMO  = 20;
  // Edges from the negedge where a raw level is driven to the edge that
  // registers the resulting output pulse: 1 to sample, DEB+1 to accept, 1 to register.
  localparam int LAT  = DEB + 3;

  typedef struct {
    int              edgeNo;
    logic            sensor;
    logic            clear;
    logic [OCCW-1:0] occ;
    logic            flt;
  } expect_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            approachRaw;
  logic            exitRaw;
  logic            trainSensor;
  logic            trainClear;
  logic [OCCW-1:0] occupancy;
  logic            fault;

  expect_t sbQueue[$];
  int      checks   = 0;
  int      failures = 0;
  int      edgeCnt  = 0;
  logic    prevFault = 1'b0;

  train_detect_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .OCC_W          (OCCW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .approach_raw(approachRaw),
    .exit_raw    (exitRaw),
    .train_sensor(trainSensor),
    .train_clear (trainClear),
    .occupancy   (occupancy),
    .fault       (fault)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count rising edges so expected pulses can be pinned to an exact edge.
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  task automatic pushExpect(input int delay, input logic s, input logic c, input logic [OCCW-1:0] o, input logic f);
    expect_t e;
    e.edgeNo = edgeCnt + delay;
    e.sensor = s;
    e.clear  = c;
    e.occ    = o;
    e.flt    = f;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic a, input logic x, input int holdCycles);
    approachRaw = a;
    exitRaw     = x;
    repeat (holdCycles) @(negedge clk);
  endtask

  // Monitor: a pulse, or the first cycle of a fault, is one presented response.
  always @(negedge clk) begin
    if (!reset && (trainSensor || trainClear) && !prevFault) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_pulse", {30'b0, trainSensor, trainClear}, 32'd0);
      end else begin
        expect_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_edge", 32'(edgeCnt), 32'(e.edgeNo));
        checkOutput("sb_sensor", 32'(trainSensor), 32'(e.sensor));
        checkOutput("sb_clear", 32'(trainClear), 32'(e.clear));
        checkOutput("sb_occ", 32'(occupancy), 32'(e.occ));
        checkOutput("sb_fault", 32'(fault), 32'(e.flt));
      end
    end
    prevFault <= fault;
  end

  initial begin
    reset       = 1'b1;
    approachRaw = 1'b0;
    exitRaw     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sensor", 32'(trainSensor), 32'd0);
    checkOutput("reset_clear", 32'(trainClear), 32'd0);
    checkOutput("reset_occ", 32'(occupancy), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    reset = 1'b0;

    // Single train enters then leaves.
    pushExpect(LAT, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("t1_occ", 32'(occupancy), 32'd1);
    applyStimulus(1'b0, 1'b1, 6);
    pushExpect(LAT, 1'b0, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("t2_occ", 32'(occupancy), 32'd0);
    checkOutput("t2_fault", 32'(fault), 32'd0);

    // Glitches shorter than the debounce window are invisible.
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("t3_occ", 32'(occupancy), 32'd0);
    checkOutput("t3_fault", 32'(fault), 32'd0);

    // Two trains in, first leave keeps occupancy, second leave clears.
    pushExpect(LAT, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 6);
    pushExpect(LAT, 1'b1, 1'b0, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("t4_occ_one_left", 32'(occupancy), 32'd1);
    checkOutput("t4_no_clear", 32'(trainClear), 32'd0);
    pushExpect(LAT, 1'b0, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 10);

    // Entry and leave accepted on the same edge at occupancy 1.
    pushExpect(LAT, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 6);
    pushExpect(LAT, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);

    // Stuck train: that last pulse lands next edge, fault TMO edges after it.
    pushExpect(1 + TMO, 1'b1, 1'b0, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 25);
    checkOutput("t5_sensor_stuck", 32'(trainSensor), 32'd1);
    checkOutput("t5_fault", 32'(fault), 32'd1);
    applyStimulus(1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, LAT);
    checkOutput("t5_no_clear_in_fault", 32'(trainClear), 32'd0);
    checkOutput("t5_sensor_held", 32'(trainSensor), 32'd1);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("t5_occ_frozen", 32'(occupancy), 32'd1);

    // Reset out of fault with approach held high through the release.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("t6_reset_sensor", 32'(trainSensor), 32'd0);
    checkOutput("t6_reset_clear", 32'(trainClear), 32'd0);
    checkOutput("t6_reset_occ", 32'(occupancy), 32'd0);
    checkOutput("t6_reset_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    pushExpect(LAT, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);

    // Fill to the counter maximum, then one more entry overflows.
    applyStimulus(1'b0, 1'b0, 6);
    pushExpect(LAT, 1'b1, 1'b0, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 6);
    pushExpect(LAT, 1'b1, 1'b0, 2'd3, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 6);
    pushExpect(LAT, 1'b1, 1'b0, 2'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("t7_overflow_fault", 32'(fault), 32'd1);
    checkOutput("t7_occ_no_wrap", 32'(occupancy), 32'd3);

    checkOutput("sb_drain", 32'(sbQueue.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
